// File: rtl/coproc_sequencer_if.sv
// -----------------------------------------------------------------------------
// coproc_sequencer_if
//
// Bundles every handshake and data signal around the coprocessor sequencer:
//   s_*   : sample request channel (valid/ready + operands + per-sample modes)
//   cp_*  : command/operand lines to the coprocessor and its result return
//   m_*   : captured result channel (valid/ready + result, latency, flags)
//   err_spur : sticky protocol-error flag
//
// Modports:
//   slave  : the sequencer itself (accepts samples, drives the coprocessor,
//            presents results)
//   master : the surrounding environment (sample source, coprocessor,
//            result sink)
// -----------------------------------------------------------------------------
interface coproc_sequencer_if;
    // Sample request channel
    logic              s_valid;
    logic              s_ready;
    logic signed [7:0] s_T;
    logic signed [7:0] s_dT;
    logic              s_init;
    logic              s_reg_mode;
    logic              s_dt_mode;

    // Coprocessor command and result
    logic              cp_start;
    logic              cp_init;
    logic signed [7:0] cp_T_in;
    logic signed [7:0] cp_dT_in;
    logic              cp_reg_mode;
    logic              cp_dt_mode;
    logic              cp_valid;
    logic [7:0]        cp_G_out;

    // Result channel
    logic              m_valid;
    logic              m_ready;
    logic [7:0]        m_G;
    logic [5:0]        m_lat;
    logic              m_timeout;
    logic              m_range;

    // Protocol error
    logic              err_spur;

    modport slave (
        input  s_valid, s_T, s_dT, s_init, s_reg_mode, s_dt_mode,
        output s_ready,
        output cp_start, cp_init, cp_T_in, cp_dT_in, cp_reg_mode, cp_dt_mode,
        input  cp_valid, cp_G_out,
        output m_valid, m_G, m_lat, m_timeout, m_range,
        input  m_ready,
        output err_spur
    );

    modport master (
        output s_valid, s_T, s_dT, s_init, s_reg_mode, s_dt_mode,
        input  s_ready,
        input  cp_start, cp_init, cp_T_in, cp_dT_in, cp_reg_mode, cp_dt_mode,
        output cp_valid, cp_G_out,
        input  m_valid, m_G, m_lat, m_timeout, m_range,
        output m_ready,
        input  err_spur
    );
endinterface

// File: rtl/coproc_sequencer.sv
// -----------------------------------------------------------------------------
// coproc_sequencer
//
// Accepts one sample at a time, optionally pulses the coprocessor's estimator
// init, pulses start, then waits for the one-cycle result strobe. The result
// is captured the cycle after the strobe (when the coprocessor data is
// stable), clamped to 0..100, and presented on the result channel together
// with the start-to-valid latency. A silent coprocessor produces a timeout
// result after TIMEOUT_CYC cycles of waiting.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset, aborts any transaction
//   bus  : coproc_sequencer_if.slave (sample, coprocessor and result signals)
//
// Parameter:
//   TIMEOUT_CYC : cycles spent waiting before a timeout result (2..63)
// -----------------------------------------------------------------------------
module coproc_sequencer #(
    parameter int TIMEOUT_CYC = 31
) (
    input  logic              clk,
    input  logic              rst,
    coproc_sequencer_if.slave bus
);
    localparam logic [5:0] TIMEOUT_LAT = 6'(TIMEOUT_CYC);
    localparam logic [7:0] G_MAX       = 8'd100;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        START,
        WAIT,
        CAPT,
        OUT
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic              ready;
    logic              accept;
    logic              resp_hit;
    logic              timeout_hit;

    logic [5:0]        cnt_reg;
    logic [5:0]        cnt_inc;

    logic signed [7:0] t_reg;
    logic signed [7:0] dt_reg;
    logic              reg_mode_reg;
    logic              dt_mode_reg;
    logic              init_reg;

    logic [7:0]        g_reg;
    logic [5:0]        lat_reg;
    logic              timeout_reg;
    logic              range_reg;
    logic              spur_reg;

    // ready is gated by rst so the sample channel is closed for the whole
    // time reset is asserted, not just from the next edge on.
    assign ready       = (state_reg == IDLE) && !rst;
    assign accept      = bus.s_valid && ready;
    assign cnt_inc     = cnt_reg + 6'd1;
    assign resp_hit    = (state_reg == WAIT) && bus.cp_valid;
    // A strobe arriving on the final waiting cycle wins over the timeout.
    assign timeout_hit = (state_reg == WAIT) && !bus.cp_valid && (cnt_inc == TIMEOUT_LAT);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = bus.s_init ? INIT : START;
                end
            end
            INIT:  state_next = START;
            START: state_next = WAIT;
            WAIT: begin
                if (resp_hit) begin
                    state_next = CAPT;
                end else if (timeout_hit) begin
                    state_next = OUT;
                end
            end
            CAPT:  state_next = OUT;
            OUT: begin
                if (bus.m_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Sample latches: operands and modes stay on the coprocessor lines
    // until the next accepted sample.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_reg        <= '0;
            dt_reg       <= '0;
            reg_mode_reg <= 1'b0;
            dt_mode_reg  <= 1'b0;
            init_reg     <= 1'b0;
        end else if (accept) begin
            t_reg        <= bus.s_T;
            dt_reg       <= bus.s_dT;
            reg_mode_reg <= bus.s_reg_mode;
            dt_mode_reg  <= bus.s_dt_mode;
            init_reg     <= bus.s_init;
        end
    end

    // ---------------------------------------------------------------------
    // Latency counter: zeroed while start is pulsed, so the first waiting
    // cycle holds 0 and a strobe there reports a latency of 1.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == START) begin
            cnt_reg <= '0;
        end else if (state_reg == WAIT) begin
            cnt_reg <= cnt_inc;
        end
    end

    // ---------------------------------------------------------------------
    // Result registers. Latency and timeout are settled in WAIT; the data
    // word is taken in CAPT, one cycle after the strobe. Nothing here moves
    // while OUT is pending, so backpressure never disturbs a result.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_reg       <= '0;
            lat_reg     <= '0;
            timeout_reg <= 1'b0;
            range_reg   <= 1'b0;
        end else begin
            if (resp_hit) begin
                lat_reg     <= cnt_inc;
                timeout_reg <= 1'b0;
            end else if (timeout_hit) begin
                lat_reg     <= TIMEOUT_LAT;
                g_reg       <= '0;
                timeout_reg <= 1'b1;
                range_reg   <= 1'b0;
            end

            if (state_reg == CAPT) begin
                if (bus.cp_G_out > G_MAX) begin
                    g_reg     <= G_MAX;
                    range_reg <= 1'b1;
                end else begin
                    g_reg     <= bus.cp_G_out;
                    range_reg <= 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Spurious strobe detector: any strobe outside WAIT is flagged and
    // otherwise ignored; only reset clears the flag.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spur_reg <= 1'b0;
        end else if (bus.cp_valid && (state_reg != WAIT)) begin
            spur_reg <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs. Pulses are pure state decodes: INIT and START are distinct
    // single-cycle states, so the two pulses can never overlap or repeat.
    // ---------------------------------------------------------------------
    assign bus.s_ready     = ready;
    assign bus.cp_init     = (state_reg == INIT);
    assign bus.cp_start    = (state_reg == START);
    assign bus.cp_T_in     = t_reg;
    assign bus.cp_dT_in    = dt_reg;
    assign bus.cp_reg_mode = reg_mode_reg;
    assign bus.cp_dt_mode  = dt_mode_reg;
    assign bus.m_valid     = (state_reg == OUT);
    assign bus.m_G         = g_reg;
    assign bus.m_lat       = lat_reg;
    assign bus.m_timeout   = timeout_reg;
    assign bus.m_range     = range_reg;
    assign bus.err_spur    = spur_reg;

    // init_reg records which path the current transaction took; it is kept
    // as part of the sample latch but the FSM already encodes the path.
    logic unused_ok;
    assign unused_ok = init_reg;

endmodule

// File: tb/tb_coproc_sequencer.sv
module tb_coproc_sequencer;
    localparam int TMO = 31;

    logic clk;
    logic rst;

    coproc_sequencer_if bus();

    coproc_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] t;
        logic [7:0] dt;
        logic       init;
        logic       regm;
        logic       dtm;
    } sample_t;

    typedef struct {
        int         acc_wait;
        int         k_init;
        int         k_start;
        int         n_init;
        int         n_start;
        bit         overlap;
        bit         opnd_bad;
        bit         got;
        int         k_mvalid;
        logic [7:0] g;
        logic [5:0] lat;
        logic       tmo;
        logic       rng;
        logic       spur;
        logic       mvalid_after;
    } obs_t;

    typedef struct {
        logic [7:0] g;
        logic [5:0] lat;
        logic       tmo;
        logic       rng;
        int         k_init;
        int         k_start;
        int         k_mvalid;
    } exp_t;

    // Reference: what a transaction should produce, from the sample, the
    // responder delay after start (<=0 means silent) and the returned value.
    function automatic exp_t model(sample_t s, int delay, logic [7:0] g);
        exp_t e;
        bit   silent;
        silent    = (delay < 1) || (delay > TMO);
        e.k_init  = s.init ? 1 : -1;
        e.k_start = s.init ? 2 : 1;
        if (silent) begin
            e.g = 8'd0; e.lat = 6'(TMO); e.tmo = 1'b1; e.rng = 1'b0;
            e.k_mvalid = e.k_start + TMO + 1;
        end else begin
            e.g   = (g > 8'd100) ? 8'd100 : g;
            e.rng = (g > 8'd100);
            e.lat = 6'(delay);
            e.tmo = 1'b0;
            e.k_mvalid = e.k_start + delay + 2;
        end
        return e;
    endfunction

    function automatic sample_t rand_sample();
        sample_t s;
        s.t    = 8'($urandom);
        s.dt   = 8'($urandom);
        s.init = 1'($urandom);
        s.regm = 1'($urandom);
        s.dtm  = 1'($urandom);
        return s;
    endfunction

    function automatic logic [38:0] all_outs();
        return {bus.s_ready, bus.cp_start, bus.cp_init, bus.cp_T_in, bus.cp_dT_in,
                bus.cp_reg_mode, bus.cp_dt_mode, bus.m_valid, bus.m_G, bus.m_lat,
                bus.m_timeout, bus.m_range, bus.err_spur};
    endfunction

    // Drives one sample, plays the coprocessor responder, and records what
    // was observed at each falling edge. k counts cycles after acceptance.
    task automatic drive_txn(input sample_t s, input int delay, input logic [7:0] g,
                             input bit release_out, output obs_t o);
        int k;
        o.acc_wait = 0; o.k_init = -1; o.k_start = -1; o.n_init = 0; o.n_start = 0;
        o.overlap = 0; o.opnd_bad = 0; o.got = 0; o.k_mvalid = -1; o.g = '0;
        o.lat = '0; o.tmo = 1'b0; o.rng = 1'b0; o.spur = 1'b0; o.mvalid_after = 1'b0;
        bus.s_T = s.t; bus.s_dT = s.dt; bus.s_init = s.init;
        bus.s_reg_mode = s.regm; bus.s_dt_mode = s.dtm; bus.s_valid = 1'b1;
        while (bus.s_ready !== 1'b1 && o.acc_wait < 50) begin
            @(negedge clk);
            o.acc_wait++;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        k = 1;
        while (k <= 100) begin
            if (bus.cp_init === 1'b1) begin o.n_init++; if (o.k_init < 0) o.k_init = k; end
            if (bus.cp_start === 1'b1) begin o.n_start++; if (o.k_start < 0) o.k_start = k; end
            if (bus.cp_init === 1'b1 && bus.cp_start === 1'b1) o.overlap = 1;
            if (bus.cp_T_in !== s.t || bus.cp_dT_in !== s.dt ||
                bus.cp_reg_mode !== s.regm || bus.cp_dt_mode !== s.dtm) o.opnd_bad = 1;
            bus.cp_valid = 1'b0;
            if (bus.m_valid === 1'b1) begin
                o.got = 1; o.k_mvalid = k; o.g = bus.m_G; o.lat = bus.m_lat;
                o.tmo = bus.m_timeout; o.rng = bus.m_range; o.spur = bus.err_spur;
                break;
            end
            // Data is garbage on the strobe cycle and valid from the next one.
            if (o.k_start > 0 && delay > 0 && k == o.k_start + delay) begin
                bus.cp_valid = 1'b1;
                bus.cp_G_out = ~g;
            end else if (o.k_start > 0 && delay > 0 && k == o.k_start + delay + 1) begin
                bus.cp_G_out = g;
            end
            @(negedge clk);
            k++;
        end
        if (o.got && release_out) begin
            bus.m_ready = 1'b1;
            @(negedge clk);
            bus.m_ready = 1'b0;
            o.mvalid_after = bus.m_valid;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (all_outs() !== 39'd0) begin miscompares++; $display("FAIL reset_zero: got %h want 0", all_outs()); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (all_outs() !== {1'b1, 38'd0}) begin miscompares++; $display("FAIL reset_release: got %h want %h", all_outs(), {1'b1, 38'd0}); end
    endtask

    task automatic test_basic();
        sample_t s; obs_t o;
        s = '{t: 8'd16, dt: 8'd0, init: 1'b0, regm: 1'b0, dtm: 1'b0};
        drive_txn(s, 7, 8'd42, 1'b1, o);
        vectors++; if (o.k_start !== 1 || o.n_start !== 1) begin miscompares++; $display("FAIL basic_start: got at %0d x%0d want at 1 x1", o.k_start, o.n_start); end
        vectors++; if (o.n_init !== 0) begin miscompares++; $display("FAIL basic_noinit: got %0d pulses want 0", o.n_init); end
        vectors++; if (o.got !== 1'b1 || o.g !== 8'd42) begin miscompares++; $display("FAIL basic_G: got %0d (valid %0d) want 42", o.g, o.got); end
        vectors++; if (o.lat !== 6'd7) begin miscompares++; $display("FAIL basic_lat: got %0d want 7", o.lat); end
        vectors++; if ({o.tmo, o.rng} !== 2'b00) begin miscompares++; $display("FAIL basic_flags: got %b want 00", {o.tmo, o.rng}); end
        vectors++; if (o.opnd_bad !== 1'b0) begin miscompares++; $display("FAIL basic_operands: got bad=%0d want 0", o.opnd_bad); end
        vectors++; if (o.mvalid_after !== 1'b0) begin miscompares++; $display("FAIL basic_release: got m_valid=%0d want 0", o.mvalid_after); end
    endtask

    task automatic test_init_mode();
        sample_t s; obs_t o; exp_t e; int d; logic [7:0] g;
        s = rand_sample(); s.init = 1'b1; s.dtm = 1'b1;
        d = $urandom_range(3, 20); g = 8'($urandom_range(0, 100));
        e = model(s, d, g);
        drive_txn(s, d, g, 1'b1, o);
        vectors++; if (o.k_init !== 1 || o.n_init !== 1) begin miscompares++; $display("FAIL init_pulse: got at %0d x%0d want at 1 x1", o.k_init, o.n_init); end
        vectors++; if (o.k_start !== 2 || o.n_start !== 1) begin miscompares++; $display("FAIL init_start: got at %0d x%0d want at 2 x1", o.k_start, o.n_start); end
        vectors++; if (o.overlap !== 1'b0) begin miscompares++; $display("FAIL init_overlap: got %0d want 0", o.overlap); end
        vectors++; if (o.opnd_bad !== 1'b0) begin miscompares++; $display("FAIL init_dtmode: got bad=%0d want 0", o.opnd_bad); end
        vectors++; if (o.g !== e.g || o.lat !== e.lat) begin miscompares++; $display("FAIL init_result: got G=%0d lat=%0d want G=%0d lat=%0d", o.g, o.lat, e.g, e.lat); end
    endtask

    task automatic test_timeout();
        int delays [4] = '{-1, TMO, TMO - 1, TMO + 1};
        sample_t s; obs_t o; exp_t e; logic [7:0] g;
        foreach (delays[i]) begin
            s = rand_sample(); g = 8'($urandom);
            e = model(s, delays[i], g);
            drive_txn(s, delays[i], g, 1'b1, o);
            vectors++; if ({o.got, o.tmo, o.rng} !== {1'b1, e.tmo, e.rng}) begin miscompares++; $display("FAIL timeout_flags d=%0d: got v/t/r=%b want %b", delays[i], {o.got, o.tmo, o.rng}, {1'b1, e.tmo, e.rng}); end
            vectors++; if (o.g !== e.g || o.lat !== e.lat) begin miscompares++; $display("FAIL timeout_data d=%0d: got G=%0d lat=%0d want G=%0d lat=%0d", delays[i], o.g, o.lat, e.g, e.lat); end
            vectors++; if (o.k_mvalid !== e.k_mvalid) begin miscompares++; $display("FAIL timeout_when d=%0d: got cycle %0d want %0d", delays[i], o.k_mvalid, e.k_mvalid); end
        end
    endtask

    task automatic test_clamp();
        logic [7:0] gs [5] = '{8'd130, 8'd100, 8'd101, 8'd255, 8'd0};
        sample_t s; obs_t o; exp_t e; int d;
        foreach (gs[i]) begin
            s = rand_sample(); d = $urandom_range(1, 12);
            e = model(s, d, gs[i]);
            drive_txn(s, d, gs[i], 1'b1, o);
            vectors++; if (o.g !== e.g || o.rng !== e.rng || o.tmo !== 1'b0) begin miscompares++; $display("FAIL clamp G_in=%0d: got G=%0d r=%0d t=%0d want G=%0d r=%0d t=0", gs[i], o.g, o.rng, o.tmo, e.g, e.rng); end
        end
    endtask

    task automatic test_random();
        sample_t s; obs_t o; exp_t e; int d; logic [7:0] g;
        for (int n = 0; n < 25; n++) begin
            s = rand_sample();
            d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 36));
            g = 8'($urandom);
            e = model(s, d, g);
            drive_txn(s, d, g, 1'b1, o);
            vectors++; if (o.k_start !== e.k_start || o.n_start !== 1 || o.k_init !== e.k_init || o.n_init !== (s.init ? 1 : 0) || o.overlap !== 1'b0)
                begin miscompares++; $display("FAIL rand%0d_pulses: got init@%0d x%0d start@%0d x%0d ovl=%0d want init@%0d start@%0d", n, o.k_init, o.n_init, o.k_start, o.n_start, o.overlap, e.k_init, e.k_start); end
            vectors++; if (o.opnd_bad !== 1'b0) begin miscompares++; $display("FAIL rand%0d_operands: got bad=%0d want 0", n, o.opnd_bad); end
            vectors++; if (o.got !== 1'b1 || o.k_mvalid !== e.k_mvalid) begin miscompares++; $display("FAIL rand%0d_when: got valid=%0d at %0d want at %0d", n, o.got, o.k_mvalid, e.k_mvalid); end
            vectors++; if (o.g !== e.g || o.lat !== e.lat || o.tmo !== e.tmo || o.rng !== e.rng)
                begin miscompares++; $display("FAIL rand%0d_result d=%0d g=%0d: got G=%0d lat=%0d t=%0d r=%0d want G=%0d lat=%0d t=%0d r=%0d", n, d, g, o.g, o.lat, o.tmo, o.rng, e.g, e.lat, e.tmo, e.rng); end
            vectors++; if (o.spur !== 1'b0 || o.mvalid_after !== 1'b0) begin miscompares++; $display("FAIL rand%0d_misc: got spur=%0d valid_after=%0d want 0 0", n, o.spur, o.mvalid_after); end
        end
    endtask

    task automatic test_backpressure();
        sample_t s1, s2; obs_t o; logic [7:0] g1, g2;
        s1 = rand_sample(); g1 = 8'($urandom_range(0, 100));
        drive_txn(s1, 5, g1, 1'b0, o);
        vectors++; if (o.got !== 1'b1 || o.g !== g1) begin miscompares++; $display("FAIL bp_first: got valid=%0d G=%0d want 1 %0d", o.got, o.g, g1); end
        s2 = rand_sample(); s2.init = 1'b0;
        bus.s_T = s2.t; bus.s_dT = s2.dt; bus.s_init = s2.init;
        bus.s_reg_mode = s2.regm; bus.s_dt_mode = s2.dtm; bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if ({bus.m_valid, bus.s_ready, bus.cp_start} !== 3'b100) begin miscompares++; $display("FAIL bp_hold_ctl%0d: got valid/ready/start=%b want 100", i, {bus.m_valid, bus.s_ready, bus.cp_start}); end
            vectors++; if (bus.m_G !== g1 || bus.m_lat !== 6'd5) begin miscompares++; $display("FAIL bp_hold_data%0d: got G=%0d lat=%0d want G=%0d lat=5", i, bus.m_G, bus.m_lat, g1); end
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        vectors++; if ({bus.m_valid, bus.s_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_release: got valid/ready=%b want 01", {bus.m_valid, bus.s_ready}); end
        g2 = 8'($urandom_range(0, 100));
        drive_txn(s2, 4, g2, 1'b1, o);
        vectors++; if (o.acc_wait !== 0 || o.k_start !== 1) begin miscompares++; $display("FAIL bp_next_accept: got wait=%0d start@%0d want 0 1", o.acc_wait, o.k_start); end
        vectors++; if (o.g !== g2 || o.lat !== 6'd4) begin miscompares++; $display("FAIL bp_next_result: got G=%0d lat=%0d want %0d 4", o.g, o.lat, g2); end
    endtask

    task automatic test_spurious();
        sample_t s; obs_t o; logic [7:0] g;
        bus.cp_valid = 1'b1; bus.cp_G_out = 8'd77;
        @(negedge clk);
        bus.cp_valid = 1'b0;
        vectors++; if (bus.err_spur !== 1'b1) begin miscompares++; $display("FAIL spur_idle_flag: got %0d want 1", bus.err_spur); end
        vectors++; if ({bus.s_ready, bus.m_valid, bus.cp_start, bus.cp_init} !== 4'b1000) begin miscompares++; $display("FAIL spur_idle_state: got %b want 1000", {bus.s_ready, bus.m_valid, bus.cp_start, bus.cp_init}); end
        s = rand_sample(); g = 8'($urandom_range(0, 100));
        drive_txn(s, 9, g, 1'b0, o);
        vectors++; if (o.got !== 1'b1 || o.g !== g || o.lat !== 6'd9) begin miscompares++; $display("FAIL spur_txn: got valid=%0d G=%0d lat=%0d want 1 %0d 9", o.got, o.g, o.lat, g); end
        bus.cp_valid = 1'b1; bus.cp_G_out = ~g;
        @(negedge clk);
        bus.cp_valid = 1'b0;
        @(negedge clk);
        vectors++; if ({bus.m_valid, bus.m_timeout, bus.err_spur} !== 3'b101 || bus.m_G !== g || bus.m_lat !== 6'd9)
            begin miscompares++; $display("FAIL spur_out_hold: got v/t/e=%b G=%0d lat=%0d want 101 %0d 9", {bus.m_valid, bus.m_timeout, bus.err_spur}, bus.m_G, bus.m_lat, g); end
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        vectors++; if ({bus.m_valid, bus.s_ready} !== 2'b01) begin miscompares++; $display("FAIL spur_release: got valid/ready=%b want 01", {bus.m_valid, bus.s_ready}); end
    endtask

    task automatic test_reset_abort();
        sample_t s; int w; bit seen;
        s = rand_sample(); s.init = 1'b0;
        bus.s_T = s.t; bus.s_dT = s.dt; bus.s_init = s.init;
        bus.s_reg_mode = s.regm; bus.s_dt_mode = s.dtm; bus.s_valid = 1'b1;
        w = 0;
        while (bus.s_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        bus.s_valid = 1'b0;
        vectors++; if (bus.cp_start !== 1'b1) begin miscompares++; $display("FAIL abort_start: got %0d want 1", bus.cp_start); end
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++; if (all_outs() !== 39'd0) begin miscompares++; $display("FAIL abort_async_zero: got %h want 0", all_outs()); end
        @(negedge clk);
        vectors++; if (all_outs() !== 39'd0) begin miscompares++; $display("FAIL abort_held_zero: got %h want 0", all_outs()); end
        rst = 1'b0;
        #1;
        vectors++; if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %0d want 1", bus.s_ready); end
        @(negedge clk);
        @(negedge clk);
        bus.cp_valid = 1'b1; bus.cp_G_out = 8'd42;
        @(negedge clk);
        bus.cp_valid = 1'b0;
        vectors++; if (bus.err_spur !== 1'b1) begin miscompares++; $display("FAIL abort_spur: got %0d want 1", bus.err_spur); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.m_valid === 1'b1 || bus.cp_start === 1'b1) seen = 1;
        end
        vectors++; if (seen !== 1'b0 || bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL abort_no_result: got stray=%0d ready=%0d want 0 1", seen, bus.s_ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (bus.err_spur !== 1'b0) begin miscompares++; $display("FAIL abort_spur_clear: got %0d want 0", bus.err_spur); end
    endtask

    initial begin
        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_T = '0; bus.s_dT = '0; bus.s_init = 1'b0;
        bus.s_reg_mode = 1'b0; bus.s_dt_mode = 1'b0;
        bus.cp_valid = 1'b0; bus.cp_G_out = '0; bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_init_mode();
        test_timeout();
        test_clamp();
        test_random();
        test_backpressure();
        test_spurious();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion by %0t want completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/coproc_sequencer.md
COPROC_SEQUENCER -- requirements
Module: coproc_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, 31, maximum cycles in WAIT before a timeout result is issued (range 2..63).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 s_valid  in  1  sample request valid.
REQ-005 s_ready  out  1  sequencer can accept a sample.
REQ-006 s_T, s_dT  in  8 each  signed temperature and external dT sample.
REQ-007 s_init  in  1  issue estimator init before this sample's start.
REQ-008 s_reg_mode, s_dt_mode  in  1 each  rule-set and dT-source mode for this sample.
REQ-009 cp_start, cp_init  out  1 each  start/init pulses to the coprocessor.
REQ-010 cp_T_in, cp_dT_in  out  8 each  operands to the coprocessor.
REQ-011 cp_reg_mode, cp_dt_mode  out  1 each  mode levels to the coprocessor.
REQ-012 cp_valid  in  1  coprocessor one-cycle result pulse.
REQ-013 cp_G_out  in  8  coprocessor result (0..100 valid range), stable from the cycle after cp_valid.
REQ-014 m_valid  out  1  result valid; m_ready  in  1  result accepted.
REQ-015 m_G  out  8  captured result; m_lat  out  6  start-to-valid latency in cycles.
REQ-016 m_timeout, m_range  out  1 each  per-result flags: no response, result clamped.
REQ-017 err_spur  out  1  sticky: cp_valid seen outside WAIT.

Function
REQ-018 FSM states SHALL be IDLE, INIT, START, WAIT, CAPT, OUT.
REQ-019 s_ready SHALL be 1 only in IDLE with rst low; handshake = s_valid & s_ready in the same cycle.
REQ-020 On accept, s_T, s_dT, s_init, s_reg_mode, s_dt_mode SHALL be latched; cp_T_in/cp_dT_in/cp_*_mode driven from latches, stable until next accept.
REQ-021 Accept with s_init=1 -> INIT next cycle; s_init=0 -> START next cycle.
REQ-022 INIT: cp_init=1 exactly one cycle, then START (cp_init low during START).
REQ-023 START: cp_start=1 exactly one cycle, latency counter cleared to 0, then WAIT.
REQ-024 WAIT: counter increments each cycle; cp_valid=1 -> m_lat=counter+1, go CAPT.
REQ-025 WAIT: counter+1 = TIMEOUT_CYC with no cp_valid -> m_G=0, m_timeout=1, m_lat=TIMEOUT_CYC, go OUT.
REQ-026 CAPT: sample cp_G_out (cycle after cp_valid); >100 -> m_G=100, m_range=1; else m_G=cp_G_out, m_range=0; go OUT.
REQ-027 OUT: m_valid=1, m_G/m_lat/flags held stable until m_ready=1; on m_valid & m_ready -> IDLE.
REQ-028 Accept-to-cp_start: 1 cycle (s_init=0) or 2 cycles (s_init=1); cp_start and cp_init never high together, never high two consecutive cycles.
REQ-029 cp_valid in any state other than WAIT SHALL set err_spur (sticky until rst) and SHALL not alter FSM or outputs.
REQ-030 cp_valid in the same cycle the timeout fires SHALL be treated as a valid response (response wins).
REQ-031 No new sample accepted while OUT pending; backpressure SHALL not drop or overwrite a result.

Reset
REQ-032 rst high SHALL immediately force IDLE and all outputs to 0 (s_ready=0, cp_*=0, m_*=0, err_spur=0), counter=0.
REQ-033 rst mid-operation SHALL abort the transaction; no m_valid for it after release; s_ready=1 first cycle after release.

Verification
REQ-034 s_T=16, s_dT=0, s_init=0; responder cp_valid 7 cycles after cp_start, G=42 -> cp_start 1 cycle exactly 1 cycle after accept; m_valid, m_G=42, m_lat=7, m_timeout=0, m_range=0.
REQ-035 s_init=1, s_dt_mode=1 -> cp_init 1 cycle at accept+1, cp_start 1 cycle at accept+2, cp_dt_mode=1 throughout.
REQ-036 Responder silent, TIMEOUT_CYC=31 -> m_valid with m_timeout=1, m_G=0, m_lat=31; cp_valid same cycle as timeout -> normal result.
REQ-037 Responder returns G=130 -> m_G=100, m_range=1; G=100 -> m_G=100, m_range=0.
REQ-038 m_ready low 5 cycles in OUT while s_valid=1 -> m_valid and m_G held, s_ready=0, no cp_start; accept 1 cycle after handshake.
REQ-039 rst asserted during WAIT, responder cp_valid 2 cycles after release -> all outputs 0 during reset, no m_valid, err_spur=1.
